// File: rtl/rgb_timebase.sv
// Free-running prescaler for the LED path: a WIDTH-bit cycle counter that emits
// one registered single-cycle strobe per tap at power-of-two rates, plus a wrap strobe.
module rgb_timebase #(
   parameter int WIDTH = 32,
   parameter int NTAPS = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [NTAPS-1:0] tap_mask,
   output logic [NTAPS-1:0] taps,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   generate
      if (WIDTH < 2 || NTAPS < 2 || NTAPS > WIDTH) begin : g_bad_params
         $error("rgb_timebase: illegal WIDTH/NTAPS combination");
      end
   endgenerate

   // Spreads the taps evenly from bit 0 to bit WIDTH-1; downstream dividers depend on this.
   function automatic int tap_bit(input int i);
      return (i * (WIDTH - 1)) / (NTAPS - 1);
   endfunction

   logic             inc;
   logic [NTAPS-1:0] tap_hit;
   logic             wrap_hit;

   assign inc      = en & ~clr;
   assign wrap_hit = &count;

   // A tap fires when the coming increment carries into bit b: count[b:0] == 0 then b ones.
   genvar gi;
   generate
      for (gi = 0; gi < NTAPS; gi++) begin : g_tap
         localparam int B = tap_bit(gi);
         localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - 1 - B);
         localparam logic [WIDTH-1:0] PATTERN  = {WIDTH{1'b1}} >> (WIDTH - B);
         assign tap_hit[gi] = ((count & LOW_MASK) == PATTERN);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
         taps  <= '0;
         wrap  <= 1'b0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
         taps  <= tap_hit & tap_mask;
         wrap  <= wrap_hit;
      end else begin
         // Paused: count holds and any strobe already out completes its single cycle.
         taps  <= '0;
         wrap  <= 1'b0;
      end
   end

endmodule
